// File: rtl/intmux_defs.sv
// Shared definitions for the interrupt source multiplexer: FSM encodings,
// the "no request" vector and the vector alignment helper.
package intmux_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] NOVEC = 8'h01;

  // Bus vectors are longword aligned, so the low two bits are forced to zero.
  function automatic logic [7:0] vec_align(input logic [7:0] v);
    return v & 8'hFC;
  endfunction

endpackage

// File: rtl/intmux_prienc.sv
// Lowest-index-wins priority encoder over the pending flags.
module prienc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      idx
);

  // Walk from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/intmux.sv
// Per-level interrupt source multiplexer feeding the bus request/grant
// controller's intvec input and acknowledging the serviced device.
module intmux
  import intmux_defs::*;
#(
  parameter int NSRC = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              init_in_h,
  input  logic [NSRC-1:0]   req_in_h,
  input  logic [8*NSRC-1:0] vec_in,
  input  logic              intr_in_h,
  input  logic              syn_ssyn_in_h,
  output logic [7:0]        intvec,
  output logic [NSRC-1:0]   ack_out_h,
  output logic [NSRC-1:0]   pend_out_h
);

  logic            rst;
  state_t          state, state_nxt;
  logic [2:0]      sel, sel_nxt;
  logic [7:0]      intvec_nxt;
  logic [NSRC-1:0] req_q, pend, pend_nxt, ack_nxt, rise;
  logic            enc_valid;
  logic [2:0]      enc_idx;
  logic [7:0]      enc_vec;
  logic            sel_live;

  assign rst        = RESET | init_in_h;
  assign rise       = req_in_h & ~req_q;
  assign pend_out_h = pend;

  prienc #(.NSRC(NSRC)) u_prienc (
    .req   (pend),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Vector of the winning source and liveness of the currently held source.
  // A source whose request line is already low counts as withdrawn this
  // cycle, so the offer is dropped on the same edge its pending flag clears.
  always_comb begin
    enc_vec  = '0;
    sel_live = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (enc_idx == 3'(i)) enc_vec = vec_in[8*i +: 8];
      if (sel == 3'(i))     sel_live = pend[i] & req_in_h[i];
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    intvec_nxt = intvec;
    ack_nxt    = '0;
    case (state)
      IDLE: begin
        intvec_nxt = NOVEC;
        if (enc_valid) begin
          sel_nxt    = enc_idx;
          intvec_nxt = vec_align(enc_vec);
          state_nxt  = OFFER;
        end
      end
      OFFER: begin
        if (intr_in_h) begin
          state_nxt = XFER;
        end else if (!sel_live) begin
          intvec_nxt = NOVEC;
          state_nxt  = HOLD;
        end
      end
      XFER: begin
        // Once the controller is transferring, withdrawal no longer matters.
        if (syn_ssyn_in_h) begin
          intvec_nxt = NOVEC;
          state_nxt  = HOLD;
          for (int i = 0; i < NSRC; i++) begin
            ack_nxt[i] = (sel == 3'(i));
          end
        end
      end
      HOLD: begin
        intvec_nxt = NOVEC;
        if (!intr_in_h && !syn_ssyn_in_h) state_nxt = IDLE;
      end
      default: begin
        intvec_nxt = NOVEC;
        state_nxt  = IDLE;
      end
    endcase
  end

  // A fresh rising edge beats an ack-clear landing in the same cycle.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NSRC; i++) begin
      if (rise[i])                      pend_nxt[i] = 1'b1;
      else if (ack_nxt[i] || !req_in_h[i]) pend_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      intvec    <= NOVEC;
      ack_out_h <= '0;
      pend      <= '0;
      req_q     <= req_in_h;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      intvec    <= intvec_nxt;
      ack_out_h <= ack_nxt;
      pend      <= pend_nxt;
      req_q     <= req_in_h;
    end
  end

endmodule

// File: tb/tb_intmux.sv
// Directed self-checking bench for intmux with NSRC=4, stepping the
// controller handshake by hand and checking registered outputs after each edge.
module tb_intmux;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        init_in_h;
  logic [3:0]  req_in_h;
  logic [31:0] vec_in;
  logic        intr_in_h;
  logic        syn_ssyn_in_h;
  logic [7:0]  intvec;
  logic [3:0]  ack_out_h;
  logic [3:0]  pend_out_h;

  int checks   = 0;
  int failures = 0;

  intmux #(.NSRC(4)) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .init_in_h     (init_in_h),
    .req_in_h      (req_in_h),
    .vec_in        (vec_in),
    .intr_in_h     (intr_in_h),
    .syn_ssyn_in_h (syn_ssyn_in_h),
    .intvec        (intvec),
    .ack_out_h     (ack_out_h),
    .pend_out_h    (pend_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic applyStimulus(input logic [3:0] req, input logic intr, input logic ssyn);
    req_in_h      = req;
    intr_in_h     = intr;
    syn_ssyn_in_h = ssyn;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] v, input logic [3:0] a, input logic [3:0] p);
    checkOutput({tag, ".intvec"}, intvec, v);
    checkOutput({tag, ".ack"}, {4'b0, ack_out_h}, {4'b0, a});
    checkOutput({tag, ".pend"}, {4'b0, pend_out_h}, {4'b0, p});
  endtask

  initial begin
    // src0=o010, src1=o020, src2=o064, src3=8'h43 (low bits must be dropped)
    vec_in    = {8'h43, 8'o064, 8'o020, 8'o010};
    RESET     = 1'b1;
    init_in_h = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick(); tick();
    RESET = 1'b0;
    checkAll("reset", 8'h01, 4'b0000, 4'b0000);

    // Single source 2
    applyStimulus(4'b0100, 1'b0, 1'b0);
    tick();
    checkAll("s2_pend", 8'h01, 4'b0000, 4'b0100);
    tick();
    checkAll("s2_offer", 8'o064, 4'b0000, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick();
    checkAll("s2_xfer", 8'o064, 4'b0000, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    tick();
    checkAll("s2_ack", 8'h01, 4'b0100, 4'b0000);
    applyStimulus(4'b0100, 1'b0, 1'b1);
    tick();
    checkAll("s2_hold", 8'h01, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkAll("s2_idle", 8'h01, 4'b0000, 4'b0000);

    // Priority: sources 3 and 1 together
    applyStimulus(4'b1010, 1'b0, 1'b0);
    tick();
    checkAll("pri_pend", 8'h01, 4'b0000, 4'b1010);
    tick();
    checkAll("pri_offer1", 8'o020, 4'b0000, 4'b1010);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1010, 1'b1, 1'b1);
    tick();
    checkAll("pri_ack1", 8'h01, 4'b0010, 4'b1000);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    tick();
    checkAll("pri_gap", 8'h01, 4'b0000, 4'b1000);
    tick();
    checkAll("pri_offer3", 8'h40, 4'b0000, 4'b1000);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick();
    // Source 0 arrives mid-transfer of source 3
    applyStimulus(4'b1001, 1'b1, 1'b0);
    tick();
    checkAll("pri_nopreempt", 8'h40, 4'b0000, 4'b1001);
    applyStimulus(4'b1001, 1'b1, 1'b1);
    tick();
    checkAll("pri_ack3", 8'h01, 4'b1000, 4'b0001);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("pri_offer0", 8'o010, 4'b0000, 4'b0001);

    // Re-arm race on source 0: falls in XFER, rises in the ack cycle
    applyStimulus(4'b1001, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick();
    checkAll("rearm_fall", 8'o010, 4'b0000, 4'b0000);
    applyStimulus(4'b1001, 1'b1, 1'b1);
    tick();
    checkAll("rearm_ack", 8'h01, 4'b0001, 4'b0001);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("rearm_offer", 8'o010, 4'b0000, 4'b0001);

    // Withdrawal of source 0 while offered, no grant
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick();
    checkAll("wd_offer", 8'h01, 4'b0000, 4'b0000);
    tick();
    tick();
    checkAll("wd_idle", 8'h01, 4'b0000, 4'b0000);

    // Withdrawal of source 1 during XFER still acknowledges
    applyStimulus(4'b1010, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("wdx_offer", 8'o020, 4'b0000, 4'b0010);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    tick();
    checkAll("wdx_xfer", 8'o020, 4'b0000, 4'b0000);
    applyStimulus(4'b1000, 1'b1, 1'b1);
    tick();
    checkAll("wdx_ack", 8'h01, 4'b0010, 4'b0000);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick();

    // INIT during XFER of source 2
    applyStimulus(4'b1100, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("init_offer", 8'o064, 4'b0000, 4'b0100);
    applyStimulus(4'b1100, 1'b1, 1'b0);
    tick();
    init_in_h = 1'b1;
    applyStimulus(4'b1100, 1'b1, 1'b1);
    tick();
    checkAll("init_clear", 8'h01, 4'b0000, 4'b0000);
    init_in_h = 1'b0;
    applyStimulus(4'b1100, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("init_nolatch", 8'h01, 4'b0000, 4'b0000);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1100, 1'b0, 1'b0);
    tick();
    checkAll("init_toggle", 8'h01, 4'b0000, 4'b0100);
    tick();
    checkAll("init_reoffer", 8'o064, 4'b0000, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intmux.md
# intmux

Per-level interrupt source multiplexer. Sits directly upstream of the single-level bus request/grant controller and drives its `intvec` input. It collects edge-triggered interrupt requests from up to NSRC devices sharing one BR level and offers the highest-priority vector. It holds that vector stable through grant and vector transfer, then returns a one-cycle acknowledge to the serviced device.

## Interface
- NSRC, 4, number of device sources (1..8); index 0 is highest priority
- CLOCK  in  1  system clock; all logic on posedge
- RESET  in  1  reset, synchronous, active-high
- init_in_h  in  1  bus INIT; identical effect to RESET
- req_in_h  in  NSRC  level interrupt condition per source (e.g. DONE & IE)
- vec_in  in  8*NSRC  vector per source; source i at [8i+7:8i]; bits [1:0] ignored
- intr_in_h  in  1  controller's intr_out_h (vector being driven on bus)
- syn_ssyn_in_h  in  1  bus SSYN, synchronized
- intvec  out  8  to controller; 8'h01 = no request, else vector with [1:0]=00
- ack_out_h  out  NSRC  one-cycle pulse to source i when its vector is accepted
- pend_out_h  out  NSRC  pending flags, for register readback/debug

## Operation
- Pending latch per source: pend[i] set on a rising edge of req_in_h[i] (registered previous value). pend[i] cleared on ack of i, or when req_in_h[i] is low (withdrawal). Set wins over ack-clear in the same cycle.
- States: IDLE, OFFER, XFER, HOLD.
- IDLE: if any pend, sel <= lowest pending index; intvec <= {vec_in[sel][7:2],2'b00}; go OFFER. Otherwise intvec = 8'h01.
- OFFER: intvec and sel are frozen. A higher-priority arrival does not preempt.
  - If intr_in_h=1: go XFER.
  - Else if pend[sel]=0 (withdrawn): intvec <= 8'h01; go HOLD.
- XFER: withdrawal is ignored; the vector is committed.
  - On syn_ssyn_in_h=1 in the same cycle the controller drops intr: intvec <= 8'h01, ack_out_h[sel] pulses, pend[sel] cleared; go HOLD.
- HOLD: intvec=8'h01. Go IDLE when intr_in_h=0 and syn_ssyn_in_h=0. Minimum one cycle.
- vec_in is sampled only on the IDLE->OFFER transition. Later changes to vec_in are ignored until the next selection.

## Timing
- Reset/INIT values: intvec=8'h01, ack_out_h=0, pend_out_h=0, state IDLE, sel=0, edge registers = current req_in_h. A request already high at reset is not latched.
- Edge to pend: 1 cycle. Pend to valid intvec: 1 cycle (IDLE->OFFER).
- intvec goes to 8'h01 on the same edge the controller clears intr_out_h. The controller therefore never sees a stale vector and cannot re-request it.
- ack_out_h is exactly one cycle wide and one-hot.
- Withdrawal in OFFER takes 1 cycle to reach intvec=8'h01. The controller tolerates this and drops its own grant without transferring.
- Reset or INIT mid-transfer: everything is cleared immediately, and no ack is issued.
- Back-to-back: minimum 2 cycles from an ack to the next valid intvec.

## Structure
- Shared package/include `intmux_defs`:
  - state encodings (IDLE=0, OFFER=1, XFER=2, HOLD=3)
  - NOVEC = 8'h01
- Sub-module `prienc`: NSRC-wide lowest-index priority encoder, giving a valid flag and a 3-bit index. Purely combinational; instantiated once.

## Test plan
- Single source, NSRC=4:
  - Stimulus: req_in_h[2] rises with vec 8'o064.
  - Required: intvec=8'o064 two cycles later.
  - Model intr_in_h high, then ssyn high: intvec=8'h01 and ack_out_h=4'b0100 on the same edge; pend[2]=0.
- Priority:
  - Stimulus: sources 3 and 1 rise together.
  - Required: vector of 1 is offered first; after its ack and HOLD, vector of 3 is offered.
  - Source 0 rising during XFER of 1 does not disturb intvec until HOLD.
- Withdrawal:
  - Stimulus: source 1 pending, in OFFER with intr_in_h=0; req_in_h[1] falls.
  - Required: intvec=8'h01 next cycle, no ack, pend[1]=0.
  - The same withdrawal during XFER still yields the ack.
- Re-arm race:
  - Stimulus: req_in_h[0] falls then rises in the ack cycle of source 0.
  - Required: pend[0] remains 1, and a second offer follows.
- Reset/INIT:
  - Stimulus: assert init_in_h during XFER.
  - Required: next cycle intvec=8'h01, pend=0, no ack pulse.
  - A request already high when init deasserts is not latched until it toggles.
